// File: rtl/nand_boot_sequencer.sv
// nand_boot_sequencer: drives nand_master through the NAND bring-up command sequence and streams page bytes.
// Build option: define NAND_SEQ_MFR_CHECK_EN to reject an ID byte 0 that differs from EXPECTED_MFR.
module nand_boot_sequencer #(
    parameter int         NUM_CHIPS      = 1,
    parameter int         ID_BYTES       = 5,
    parameter int         PAGE_BYTES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] EXPECTED_MFR   = 8'h2C,
    localparam int        CS_W           = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [CS_W-1:0] chip_sel,
    output logic [5:0]      nm_cmd,
    output logic [7:0]      nm_data_in,
    output logic            nm_activate,
    input  logic            nm_busy,
    input  logic [7:0]      nm_data_out,
    output logic            seq_busy,
    output logic            seq_done,
    output logic            seq_error,
    output logic [3:0]      err_state,
    output logic            id_valid,
    output logic [2:0]      id_index,
    output logic [7:0]      id_byte,
    output logic [7:0]      status_byte,
    output logic            pg_valid,
    input  logic            pg_ready,
    output logic [7:0]      pg_data,
    output logic            pg_last
);
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       ID_LAST  = 3'(ID_BYTES - 1);
    localparam logic [15:0]      PG_LAST  = 16'(PAGE_BYTES - 1);

    // state | meaning: IDLE wait start | CTRL_RST..GET_BYTE command issue/gap/wait |
    // PG_HOLD page byte offered on stream | DONE success pulse | ERROR timeout or bad ID, back to IDLE
    typedef enum logic [3:0] {
        IDLE = 4'd0, CTRL_RST = 4'd1, CHIP_EN = 4'd2, NAND_RST = 4'd3, READ_ID = 4'd4,
        GET_ID = 4'd5, GET_STAT = 4'd6, RST_IDX_A = 4'd7, PAGE_RD = 4'd8, RST_IDX_B = 4'd9,
        GET_BYTE = 4'd10, PG_HOLD = 4'd11, DONE = 4'd12, ERROR = 4'd13
    } state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_GAP, PH_WAIT} phase_t;

    state_t            state, state_nx;
    phase_t            phase, phase_nx;
    logic              is_cmd, accept, issue, enter_err, cap_id, cap_stat, cap_pg, pg_xfer, mfr_bad;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [2:0]        id_cnt;
    logic [15:0]       pg_cnt;
    logic [CS_W-1:0]   cs_q;

    function automatic logic [5:0] cmd_code(input state_t s);
        case (s)
            CTRL_RST:             return 6'h01;
            CHIP_EN:              return 6'h0E;
            NAND_RST:             return 6'h04;
            READ_ID:              return 6'h06;
            GET_ID:               return 6'h13;
            GET_STAT:             return 6'h0D;
            RST_IDX_A, RST_IDX_B: return 6'h12;
            PAGE_RD:              return 6'h09;
            GET_BYTE:             return 6'h15;
            default:              return 6'h00;
        endcase
    endfunction

`ifdef NAND_SEQ_MFR_CHECK_EN
    assign mfr_bad = (id_cnt == 3'd0) && (nm_data_out != EXPECTED_MFR);
`else
    assign mfr_bad = 1'b0 & (^EXPECTED_MFR);
`endif

    assign is_cmd      = (state >= CTRL_RST) && (state <= GET_BYTE);
    assign nm_activate = is_cmd && (phase == PH_ISSUE);
    assign seq_busy    = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign seq_done    = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= PH_ISSUE;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        accept    = 1'b0;
        issue     = 1'b0;
        enter_err = 1'b0;
        cap_id    = 1'b0;
        cap_stat  = 1'b0;
        cap_pg    = 1'b0;
        pg_xfer   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !nm_busy) begin
                    state_nx = CTRL_RST;
                    phase_nx = PH_ISSUE;
                    accept   = 1'b1;
                    issue    = 1'b1;
                end
            end
            PG_HOLD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pg_valid && pg_ready) begin
                    pg_xfer = 1'b1;
                    if (pg_cnt == PG_LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = GET_BYTE;
                        phase_nx = PH_ISSUE;
                        issue    = 1'b1;
                    end
                end
            end
            DONE, ERROR: state_nx = IDLE;
            default: begin
                // abort outranks a timeout expiring in the same cycle
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    case (phase)
                        PH_ISSUE: phase_nx = PH_GAP;
                        PH_GAP:   phase_nx = PH_WAIT;
                        default: begin
                            if (nm_busy) begin
                                if (tmo_cnt == '0) begin
                                    state_nx  = ERROR;
                                    enter_err = 1'b1;
                                end
                            end else begin
                                phase_nx = PH_ISSUE;
                                issue    = 1'b1;
                                case (state)
                                    CTRL_RST:  state_nx = CHIP_EN;
                                    CHIP_EN:   state_nx = NAND_RST;
                                    NAND_RST:  state_nx = READ_ID;
                                    READ_ID:   state_nx = GET_ID;
                                    GET_ID: begin
                                        cap_id = 1'b1;
                                        if (mfr_bad) begin
                                            state_nx  = ERROR;
                                            enter_err = 1'b1;
                                            issue     = 1'b0;
                                        end else if (id_cnt == ID_LAST) begin
                                            state_nx = GET_STAT;
                                        end
                                    end
                                    GET_STAT: begin
                                        cap_stat = 1'b1;
                                        state_nx = RST_IDX_A;
                                    end
                                    RST_IDX_A: state_nx = PAGE_RD;
                                    PAGE_RD:   state_nx = RST_IDX_B;
                                    RST_IDX_B: state_nx = GET_BYTE;
                                    GET_BYTE: begin
                                        cap_pg   = 1'b1;
                                        state_nx = PG_HOLD;
                                        issue    = 1'b0;
                                    end
                                    default:   state_nx = IDLE;
                                endcase
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nm_cmd      <= '0;
            nm_data_in  <= '0;
            seq_error   <= 1'b0;
            err_state   <= '0;
            id_valid    <= 1'b0;
            id_index    <= '0;
            id_byte     <= '0;
            status_byte <= '0;
            pg_valid    <= 1'b0;
            pg_data     <= '0;
            pg_last     <= 1'b0;
            tmo_cnt     <= '0;
            id_cnt      <= '0;
            pg_cnt      <= '0;
            cs_q        <= '0;
        end else begin
            id_valid <= 1'b0;
            if (accept) begin
                seq_error <= 1'b0;
                err_state <= '0;
                cs_q      <= chip_sel;
                id_cnt    <= '0;
                pg_cnt    <= '0;
            end
            if (issue) begin
                nm_cmd     <= cmd_code(state_nx);
                nm_data_in <= (state_nx == CHIP_EN) ? 8'(cs_q) : 8'h00;
                tmo_cnt    <= TMO_INIT;
            end else if (is_cmd && phase == PH_WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (enter_err) begin
                seq_error <= 1'b1;
                err_state <= state;
            end
            if (cap_id) begin
                id_valid <= 1'b1;
                id_index <= id_cnt;
                id_byte  <= nm_data_out;
                id_cnt   <= id_cnt + 3'd1;
            end
            if (cap_stat) status_byte <= nm_data_out;
            if (cap_pg) begin
                pg_data  <= nm_data_out;
                pg_valid <= 1'b1;
                pg_last  <= (pg_cnt == PG_LAST);
            end
            if (pg_xfer) begin
                pg_valid <= 1'b0;
                pg_last  <= 1'b0;
                pg_cnt   <= pg_cnt + 16'd1;
            end
            if (abort && state != IDLE) begin
                pg_valid <= 1'b0;
                pg_last  <= 1'b0;
            end
        end
    end
endmodule
